// File: rtl/d_sram_like_bridge.sv
// Data-side bridge: turns the M-stage single-cycle load/store into one sram_like
// req/addr_ok/data_ok transaction, stalling the pipeline until it completes.
module d_sram_like_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_en,
   input  logic [3:0]        cpu_wen,
   input  logic [1:0]        cpu_size,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_flush,
   input  logic              cpu_longest_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_killed;
   logic              r_wr;
   logic [1:0]        r_size;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic w_idle;
   logic w_issue;
   logic w_wr;
   logic w_kill;
   logic w_accept;
   logic w_done_ok;
   logic w_capture;

   assign w_idle    = (r_state == S_IDLE);
   assign w_issue   = w_idle & cpu_en & ~cpu_flush;
   assign w_wr      = w_idle ? (|cpu_wen) : r_wr;
   assign w_kill    = r_killed | cpu_flush;
   assign w_accept  = (w_issue | (r_state == S_ADDR)) & data_addr_ok;
   // data_ok only counts once the address has been (or is being) accepted
   assign w_done_ok = data_data_ok & (w_accept | (r_state == S_DATA));
   assign w_capture = w_done_ok & ~w_wr & ~w_kill;

   // Request fields pass straight through in IDLE so issue costs no extra cycle.
   assign data_req   = ~rst & (w_issue | (r_state == S_ADDR));
   assign data_wr    = w_wr;
   assign data_size  = w_idle ? cpu_size  : r_size;
   assign data_addr  = w_idle ? cpu_addr  : r_addr;
   assign data_wdata = w_idle ? cpu_wdata : r_wdata;

   assign cpu_stall = ~rst & cpu_en & ~cpu_flush & (r_state != S_DONE) & ~r_killed;
   assign cpu_rdata = (~rst && r_state == S_DONE) ? r_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_killed <= 1'b0;
         r_wr     <= 1'b0;
         r_size   <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else begin
         if (w_capture) begin
            r_rdata <= data_rdata;
         end
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_wr    <= |cpu_wen;
                  r_size  <= cpu_size;
                  r_addr  <= cpu_addr;
                  r_wdata <= cpu_wdata;
                  if (data_addr_ok && data_data_ok) begin
                     r_state <= S_DONE;
                  end else if (data_addr_ok) begin
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (cpu_flush) begin
                  r_killed <= 1'b1;
               end
               if (data_addr_ok && data_data_ok) begin
                  if (w_kill) begin
                     r_state  <= S_IDLE;
                     r_killed <= 1'b0;
                  end else begin
                     r_state <= S_DONE;
                  end
               end else if (data_addr_ok) begin
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (cpu_flush) begin
                  r_killed <= 1'b1;
               end
               // a killed access drains the bus and skips DONE entirely
               if (data_data_ok) begin
                  if (w_kill) begin
                     r_state  <= S_IDLE;
                     r_killed <= 1'b0;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (!cpu_longest_stall || cpu_flush) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Scoreboard bench for d_sram_like_bridge: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_d_sram_like_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_en = 1'b0;
   logic [3:0]  cpu_wen = '0;
   logic [1:0]  cpu_size = '0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_flush = 1'b0;
   logic        cpu_longest_stall = 1'b0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok = 1'b0;
   logic        data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;

   always #5 clk = ~clk;

   d_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_en            (cpu_en),
      .cpu_wen           (cpu_wen),
      .cpu_size          (cpu_size),
      .cpu_addr          (cpu_addr),
      .cpu_wdata         (cpu_wdata),
      .cpu_flush         (cpu_flush),
      .cpu_longest_stall (cpu_longest_stall),
      .cpu_rdata         (cpu_rdata),
      .cpu_stall         (cpu_stall),
      .data_req          (data_req),
      .data_wr           (data_wr),
      .data_size         (data_size),
      .data_addr         (data_addr),
      .data_wdata        (data_wdata),
      .data_addr_ok      (data_addr_ok),
      .data_data_ok      (data_data_ok),
      .data_rdata        (data_rdata)
   );

   typedef struct {
      string       name;
      logic        req;
      logic        stall;
      logic [31:0] rdata;
      logic        chk_bus;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // expected bus request fields for the access currently being issued
   logic        eb_wr;
   logic [1:0]  eb_size;
   logic [31:0] eb_addr;
   logic [31:0] eb_wdata;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, got, want);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         $display("%-12s req=%b stall=%b rdata=%h wr=%b size=%0d addr=%h",
                  e.name, data_req, cpu_stall, cpu_rdata, data_wr, data_size, data_addr);
         chk({e.name, ".req"},   {31'd0, data_req},  {31'd0, e.req});
         chk({e.name, ".stall"}, {31'd0, cpu_stall}, {31'd0, e.stall});
         chk({e.name, ".rdata"}, cpu_rdata, e.rdata);
         if (e.chk_bus) begin
            chk({e.name, ".wr"},    {31'd0, data_wr},   {31'd0, e.wr});
            chk({e.name, ".size"},  {30'd0, data_size}, {30'd0, e.size});
            chk({e.name, ".addr"},  data_addr,  e.addr);
            chk({e.name, ".wdata"}, data_wdata, e.wdata);
         end
      end
   end

   task op(input logic [3:0] wen, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      cpu_wen   = wen;
      cpu_size  = sz;
      cpu_addr  = a;
      cpu_wdata = wd;
      eb_wr     = |wen;
      eb_size   = sz;
      eb_addr   = a;
      eb_wdata  = wd;
   endtask

   task setpush(input string nm, input logic en, input logic flush, input logic lstall,
                input logic aok, input logic dok, input logic [31:0] rd,
                input logic e_req, input logic e_stall, input logic [31:0] e_rd);
      exp_t e;
      cpu_en            = en;
      cpu_flush         = flush;
      cpu_longest_stall = lstall;
      data_addr_ok      = aok;
      data_data_ok      = dok;
      data_rdata        = rd;
      e.name    = nm;
      e.req     = e_req;
      e.stall   = e_stall;
      e.rdata   = e_rd;
      e.chk_bus = e_req;
      e.wr      = eb_wr;
      e.size    = eb_size;
      e.addr    = eb_addr;
      e.wdata   = eb_wdata;
      exp_q.push_back(e);
   endtask

   task cyc(input string nm, input logic en, input logic flush, input logic lstall,
            input logic aok, input logic dok, input logic [31:0] rd,
            input logic e_req, input logic e_stall, input logic [31:0] e_rd);
      setpush(nm, en, flush, lstall, aok, dok, rd, e_req, e_stall, e_rd);
      @(posedge clk);
      #1;
   endtask

   initial begin
      op(4'b0000, 2'd2, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      // outputs held low while reset is asserted, even with a request pending
      cyc("rst",     1, 0, 0, 1, 1, 32'h1111_1111, 0, 0, 32'h0);
      rst = 1'b0;

      // load word, addr_ok then data_ok, followed by a back-to-back load with both acks together
      op(4'b0000, 2'd2, 32'hBFC0_1000, 32'h0);
      cyc("t1_c0",   1, 0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
      cyc("t1_c1",   1, 0, 0, 0, 1, 32'h1234_5678, 0, 1, 32'h0);
      cyc("t1_c2",   1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h1234_5678);
      op(4'b0000, 2'd2, 32'hBFC0_1004, 32'h0);
      cyc("t3_c0",   1, 0, 0, 1, 1, 32'hA5A5_A5A5, 1, 1, 32'h0);
      cyc("t3_c1",   0, 0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'hA5A5_A5A5);
      cyc("t3_c2",   0, 0, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A5A5);

      // store byte with addr_ok delayed; cpu side changes must not leak onto the bus
      op(4'b0100, 2'd0, 32'h8000_0002, 32'h00AB_0000);
      cyc("t2_s0",   1, 0, 0, 0, 0, 32'h0,         1, 1, 32'h0);
      cpu_addr  = 32'hDEAD_0000;
      cpu_wdata = 32'hFFFF_FFFF;
      cyc("t2_s1",   1, 0, 0, 0, 0, 32'h0,         1, 1, 32'h0);
      cyc("t2_s2",   1, 0, 0, 0, 0, 32'h0,         1, 1, 32'h0);
      cyc("t2_s3",   1, 0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
      cyc("t2_s4",   1, 0, 0, 0, 1, 32'h7777_7777, 0, 1, 32'h0);
      cyc("t2_s5",   1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A5A5);
      cyc("t2_s6",   0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);

      // completed load held under a global freeze while the bus data wanders
      op(4'b0000, 2'd2, 32'h0000_1000, 32'h0);
      cyc("t4_l0",   1, 0, 0, 1, 1, 32'hCAFE_BABE, 1, 1, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc($sformatf("t4_hold%0d", i), 1, 0, 1, 0, i[0], $urandom, 0, 0, 32'hCAFE_BABE);
      end
      cyc("t4_rel",  1, 0, 0, 0, 0, 32'h0,         0, 0, 32'hCAFE_BABE);
      cyc("t4_idle", 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);

      // flush while waiting for data: drain silently, then serve a fresh load
      op(4'b0000, 2'd2, 32'h0000_2000, 32'h0);
      cyc("t5_f0",   1, 0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
      cyc("t5_f1",   1, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0);
      op(4'b0000, 2'd2, 32'h0000_3000, 32'h0);
      cyc("t5_f2",   1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);
      cyc("t5_f3",   1, 0, 0, 0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0);
      cyc("t5_f4",   1, 0, 0, 1, 0, 32'h0,         1, 1, 32'h0);
      cyc("t5_f5",   1, 0, 0, 0, 1, 32'h55AA_33CC, 0, 1, 32'h0);
      cyc("t5_f6",   1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h55AA_33CC);
      cyc("t5_f7",   0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);

      // asynchronous reset in the middle of the address phase
      op(4'b0000, 2'd2, 32'h0000_4000, 32'h0);
      cyc("t6_r0",   1, 0, 0, 0, 0, 32'h0,         1, 1, 32'h0);
      setpush("t6_r1", 1, 0, 0, 0, 0, 32'h0,       1, 1, 32'h0);
      #6;
      rst = 1'b1;
      #1;
      chk("t6_async.req",   {31'd0, data_req},  32'h0);
      chk("t6_async.stall", {31'd0, cpu_stall}, 32'h0);
      chk("t6_async.rdata", cpu_rdata,          32'h0);
      @(posedge clk);
      #1;
      cyc("t6_r2",   1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);
      rst = 1'b0;
      // a new address on the bus proves the FSM restarted from IDLE, not ADDR
      op(4'b0000, 2'd2, 32'h0000_5000, 32'h0);
      cyc("t6_r3",   1, 0, 0, 1, 1, 32'h600D_F00D, 1, 1, 32'h0);
      cyc("t6_r4",   0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h600D_F00D);
      cyc("t6_r5",   0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
